// File: rtl/spike_packet_arbiter.sv
// spike_packet_arbiter: front end of the axon scheduler.
// Accepts spike packets from N_PORTS requesters over valid/ready and
// grants them round-robin onto the scheduler's single write port.
// Packets with delay 4'hF would alias the current slot, so they are
// accepted, counted and discarded. It also sequences each timestep
// tick as clear-slot then advance-pointer. Packet writes are kept
// out of those two cycles.
module spike_packet_arbiter #(
  parameter int N_PORTS  = 4,
  parameter int PACKET_W = 12,
  parameter int DROP_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PORTS-1:0]            req_valid,
  input  logic [N_PORTS*PACKET_W-1:0]   req_packet,
  output logic [N_PORTS-1:0]            req_ready,
  input  logic                          tick,
  input  logic                          clear_status,
  output logic                          sched_wen,
  output logic [PACKET_W-1:0]           sched_packet,
  output logic                          sched_clr,
  output logic                          sched_set,
  output logic                          tick_done,
  output logic                          busy,
  output logic [DROP_W-1:0]             drop_count,
  output logic                          overrun
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  // A packet with this delay would alias the slot being read.
  localparam logic [3:0] ALIAS_DELAY = 4'hF;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    CLEAR   = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_found;
  logic [PACKET_W-1:0]  grant_packet;
  logic                 grant_drop;
  logic                 transfer;
  logic                 write_pkt;
  logic                 drop_pkt;

  // Round-robin search: the first valid port at or above ptr_q, with wrap.
  always_comb begin : rr_search
    // NOTE: every variable written here gets a default first. A path that
    // leaves one unassigned would infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin : scan
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_PORTS) begin
        idx = idx - N_PORTS;
      end
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  // Next state and per-port ready. A tick in RUN takes priority over packets.
  always_comb begin : fsm_next
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      RUN: begin
        if (tick) begin
          state_d = CLEAR;
        end else if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
        end
      end
      CLEAR:   state_d = ADVANCE;
      ADVANCE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The granted packet and its classification. Only the low nibble is the delay.
  assign grant_packet = req_packet[int'(grant_idx)*PACKET_W +: PACKET_W];
  assign grant_drop   = (grant_packet[3:0] == ALIAS_DELAY);
  assign transfer     = |(req_valid & req_ready);
  assign write_pkt    = transfer && !grant_drop;
  assign drop_pkt     = transfer && grant_drop;

  // Tick-sequence strobes are decoded directly from the registered state.
  assign sched_clr = (state_q == CLEAR);
  assign sched_set = (state_q == ADVANCE);
  assign busy      = (state_q != RUN);

  // State register.
  always_ff @(posedge clk) begin : state_reg
    // NOTE: state updates use non-blocking assignments. Every flop then
    // samples pre-edge values, whatever order the blocks run in.
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority pointer. It moves past the winner only when a handshake completes.
  always_ff @(posedge clk) begin : ptr_reg
    if (reset) begin
      ptr_q <= '0;
    end else if (transfer) begin
      if (grant_idx == PTR_W'(N_PORTS - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= grant_idx + 1'b1;
      end
    end
  end

  // Output stage. The packet is loaded only when it is written, so
  // sched_packet holds its last value while sched_wen is low.
  always_ff @(posedge clk) begin : out_reg
    if (reset) begin
      sched_wen    <= 1'b0;
      sched_packet <= '0;
    end else begin
      sched_wen <= write_pkt;
      if (write_pkt) begin
        sched_packet <= grant_packet;
      end
    end
  end

  // tick_done pulses in the cycle after ADVANCE, as the FSM re-enters RUN.
  always_ff @(posedge clk) begin : done_reg
    if (reset) begin
      tick_done <= 1'b0;
    end else begin
      tick_done <= (state_q == ADVANCE);
    end
  end

  // Status: the drop counter saturates, and overrun is sticky.
  // clear_status wins over a same-cycle event.
  always_ff @(posedge clk) begin : status_reg
    if (reset) begin
      drop_count <= '0;
      overrun    <= 1'b0;
    end else if (clear_status) begin
      drop_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (drop_pkt && (drop_count != {DROP_W{1'b1}})) begin
        drop_count <= drop_count + 1'b1;
      end
      if (tick && (state_q != RUN)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_packet_arbiter.sv
// Self-checking bench for spike_packet_arbiter.
// A cycle-level reference model tracks the arbitration pointer, the
// remaining tick-sequence cycles and the status counters. The model's
// expectations are compared against the DUT every cycle.
module tb_spike_packet_arbiter;

  localparam int N  = 4;
  localparam int PW = 12;
  localparam int DW = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_packet;
  logic [N-1:0]    req_ready;
  logic            tick;
  logic            clear_status;
  logic            sched_wen;
  logic [PW-1:0]   sched_packet;
  logic            sched_clr;
  logic            sched_set;
  logic            tick_done;
  logic            busy;
  logic [DW-1:0]   drop_count;
  logic            overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_ptr;
  int          m_busy_left;   // cycles of tick sequence still to run (2 = clearing, 1 = advancing)
  logic        m_wen;
  logic [11:0] m_pkt;
  logic        m_done;
  int          m_drop;
  logic        m_ovr;

  spike_packet_arbiter #(.N_PORTS(N), .PACKET_W(PW), .DROP_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_packet   (req_packet),
    .req_ready    (req_ready),
    .tick         (tick),
    .clear_status (clear_status),
    .sched_wen    (sched_wen),
    .sched_packet (sched_packet),
    .sched_clr    (sched_clr),
    .sched_set    (sched_set),
    .tick_done    (tick_done),
    .busy         (busy),
    .drop_count   (drop_count),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // First valid port found scanning upward from p with wrap, or -1.
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [11:0] port_pkt(input int i);
    return req_packet[i*PW +: PW];
  endfunction

  task automatic set_port(input int i, input logic [7:0] axon, input logic [3:0] dly);
    req_packet[i*PW +: PW] = {axon, dly};
  endtask

  task automatic model_reset();
    m_ptr = 0; m_busy_left = 0; m_wen = 0; m_pkt = '0;
    m_done = 0; m_drop = 0; m_ovr = 0;
  endtask

  // One clock cycle. Inputs are already driven. This checks req_ready
  // before the edge, advances the model at the edge, then checks the
  // registered outputs.
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    logic [11:0]  p;
    g = (m_busy_left > 0 || tick) ? -1 : model_grant(req_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      p = (g >= 0) ? port_pkt(g) : 12'h000;
      m_wen  = (g >= 0) && (p[3:0] != 4'hF);
      if (m_wen) m_pkt = p;
      if (g >= 0) m_ptr = (g + 1) % N;
      m_done = (m_busy_left == 1);
      if (clear_status) begin
        m_drop = 0;
        m_ovr  = 0;
      end else begin
        if (g >= 0 && p[3:0] == 4'hF && m_drop < 255) m_drop++;
        if (tick && m_busy_left > 0) m_ovr = 1;
      end
      if (m_busy_left > 0) m_busy_left--;
      else if (tick) m_busy_left = 2;
    end
    #1;
    check("sched_wen",    32'(sched_wen),    32'(m_wen));
    check("sched_packet", 32'(sched_packet), 32'(m_pkt));
    check("sched_clr",    32'(sched_clr),    32'(m_busy_left == 2));
    check("sched_set",    32'(sched_set),    32'(m_busy_left == 1));
    check("tick_done",    32'(tick_done),    32'(m_done));
    check("busy",         32'(busy),         32'(m_busy_left > 0));
    check("drop_count",   32'(drop_count),   32'(m_drop));
    check("overrun",      32'(overrun),      32'(m_ovr));
    @(negedge clk);
  endtask

  task automatic all_valid_delays_1_to_4();
    req_valid = '1;
    for (int i = 0; i < N; i++) set_port(i, 8'(8'h10 + i), 4'(i + 1));
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_packet = '0; tick = 0; clear_status = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Idle after reset: nothing granted, every output stays low.
    for (int c = 0; c < 3; c++) step();

    // All ports are valid, so grants rotate 0,1,2,3,0 with one write per cycle.
    all_valid_delays_1_to_4();
    for (int c = 0; c < 9; c++) step();

    // A tick with ports valid: three cycles of no grants, clear, set, done.
    tick = 1; step(); tick = 0;
    for (int c = 0; c < 5; c++) step();

    // Back-to-back ticks: the second one only raises overrun, then clear_status.
    tick = 1; step(); step(); tick = 0;
    for (int c = 0; c < 4; c++) step();
    check("overrun_sticky", 32'(overrun), 32'd1);
    clear_status = 1; step(); clear_status = 0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Port 2 sends only aliasing packets, so drop_count saturates at 255.
    req_valid = 4'b0100;
    set_port(2, 8'hAB, 4'hF);
    for (int c = 0; c < 300; c++) step();
    check("drop_saturated", 32'(drop_count), 32'd255);
    req_valid = '0;
    clear_status = 1; step(); clear_status = 0;

    // Reset in the CLEAR cycle: no set pulse, and ptr returns to 0.
    all_valid_delays_1_to_4();
    step(); step();
    tick = 1; step(); tick = 0;
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 5; c++) step();

    // Randomized traffic with occasional ticks, status clears and resets.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        set_port(i, 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14)));
      end
      tick         = ($urandom_range(0, 19) == 0);
      clear_status = ($urandom_range(0, 49) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0; tick = 0; clear_status = 0; req_valid = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
